// File: rtl/exe_stage_pkg.sv
// ---------------------------------------------------------------------------
// exe_stage_pkg
//   Shared definitions for the execute stage: bus widths, field offsets of the
//   ID->EX, EX->MS and EX->ID bypass buses, memory access size encodings and
//   the one-hot alu_op bit indices.
// ---------------------------------------------------------------------------
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 154;
    localparam int ES_TO_MS_BUS_WD = 76;
    localparam int ES_FWD_BUS_WD   = 39;

    // ID->EX bus: pc, alu_op, src1, src2, rkd, gr_we, dest, mem_we,
    //             res_from_mem, mem_size, mem_unsigned (MSB->LSB)
    localparam int DS_PC_LSB       = 122;
    localparam int DS_ALU_OP_LSB   = 107;
    localparam int DS_SRC1_LSB     = 75;
    localparam int DS_SRC2_LSB     = 43;
    localparam int DS_RKD_LSB      = 11;
    localparam int DS_GR_WE        = 10;
    localparam int DS_DEST_LSB     = 5;
    localparam int DS_MEM_WE       = 4;
    localparam int DS_RES_FROM_MEM = 3;
    localparam int DS_MEM_SIZE_LSB = 1;
    localparam int DS_MEM_UNSIGNED = 0;

    // EX->MS bus: pc, alu_result, gr_we, dest, res_from_mem, mem_size,
    //             mem_unsigned, addr_low (MSB->LSB)
    localparam int MS_PC_LSB       = 44;
    localparam int MS_RESULT_LSB   = 12;
    localparam int MS_GR_WE        = 11;
    localparam int MS_DEST_LSB     = 6;
    localparam int MS_RES_FROM_MEM = 5;
    localparam int MS_MEM_SIZE_LSB = 3;
    localparam int MS_MEM_UNSIGNED = 2;
    localparam int MS_ADDR_LOW_LSB = 0;

    // EX->ID bypass bus: fwd_we, fwd_dest, fwd_data, fwd_is_load (MSB->LSB)
    localparam int FWD_WE          = 38;
    localparam int FWD_DEST_LSB    = 33;
    localparam int FWD_DATA_LSB    = 1;
    localparam int FWD_IS_LOAD     = 0;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_e;

    // One-hot alu_op bit positions.
    localparam int ALU_OP_W   = 15;
    localparam int OP_ADD     = 0;
    localparam int OP_SUB     = 1;
    localparam int OP_SLT     = 2;
    localparam int OP_SLTU    = 3;
    localparam int OP_AND     = 4;
    localparam int OP_NOR     = 5;
    localparam int OP_OR      = 6;
    localparam int OP_XOR     = 7;
    localparam int OP_SLL     = 8;
    localparam int OP_SRL     = 9;
    localparam int OP_SRA     = 10;
    localparam int OP_LUI     = 11;
    localparam int OP_MUL_W   = 12;
    localparam int OP_MULH_W  = 13;
    localparam int OP_MULH_WU = 14;

endpackage

// File: rtl/exe_stage_if.sv
// ---------------------------------------------------------------------------
// exe_stage_if
//   Data SRAM request bus issued by the execute stage.
//     data_sram_en    : request strobe
//     data_sram_we    : byte write enables
//     data_sram_addr  : byte address
//     data_sram_wdata : write data, lane-replicated
//   master = requester (exe_stage), slave = memory side.
// ---------------------------------------------------------------------------
interface exe_stage_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Combinational integer ALU driven by a one-hot operation select.
//     alu_op     : one-hot operation (bit indices in exe_stage_pkg)
//     alu_src1   : operand 1
//     alu_src2   : operand 2 (shift amount in [4:0], immediate for LUI)
//     alu_result : result
// ---------------------------------------------------------------------------
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         alu_src1,
    input  logic [31:0]         alu_src2,
    output logic [31:0]         alu_result
);

    logic [31:0] add_res, sub_res, sra_res, mulh_s;
    logic [63:0] mul_u;
    logic        slt_res, sltu_res;

    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
    assign sltu_res = alu_src1 < alu_src2;
    assign sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

    // One unsigned 32x32 multiplier serves all three multiply ops; the signed
    // high word is the unsigned high word corrected for negative operands.
    assign mul_u  = {32'd0, alu_src1} * {32'd0, alu_src2};
    assign mulh_s = mul_u[63:32]
                  - (alu_src1[31] ? alu_src2 : 32'd0)
                  - (alu_src2[31] ? alu_src1 : 32'd0);

    assign alu_result = ({32{alu_op[OP_ADD]}}     & add_res)
                      | ({32{alu_op[OP_SUB]}}     & sub_res)
                      | ({32{alu_op[OP_SLT]}}     & {31'd0, slt_res})
                      | ({32{alu_op[OP_SLTU]}}    & {31'd0, sltu_res})
                      | ({32{alu_op[OP_AND]}}     & (alu_src1 & alu_src2))
                      | ({32{alu_op[OP_NOR]}}     & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[OP_OR]}}      & (alu_src1 | alu_src2))
                      | ({32{alu_op[OP_XOR]}}     & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[OP_SLL]}}     & (alu_src1 << alu_src2[4:0]))
                      | ({32{alu_op[OP_SRL]}}     & (alu_src1 >> alu_src2[4:0]))
                      | ({32{alu_op[OP_SRA]}}     & sra_res)
                      | ({32{alu_op[OP_LUI]}}     & alu_src2)
                      | ({32{alu_op[OP_MUL_W]}}   & mul_u[31:0])
                      | ({32{alu_op[OP_MULH_W]}}  & mulh_s)
                      | ({32{alu_op[OP_MULH_WU]}} & mul_u[63:32]);

endmodule

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
//   Execute stage between ID and MS. Holds one instruction, computes its
//   result with the alu, issues the data SRAM request for loads/stores and
//   publishes a bypass bus back to ID.
//     clk, reset      : clock, asynchronous active-high reset
//     flush           : kill the instruction held in EX
//     ds_to_es_valid/ds_to_es_bus, es_allowin : ID->EX handshake
//     es_to_ms_valid/es_to_ms_bus, ms_allowin : EX->MS handshake
//     es_fwd_bus      : {fwd_we, fwd_dest, fwd_data, fwd_is_load} to ID
//     sram            : data SRAM request bus
// ---------------------------------------------------------------------------
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
    exe_stage_if.master                sram
);

    localparam logic ES_READY_GO = 1'b1;  // single-cycle execute

    logic                       es_valid_q, es_valid_d;
    logic [DS_TO_ES_BUS_WD-1:0] ds_bus_q, ds_bus_d;

    assign es_allowin     = !es_valid_q || (ES_READY_GO && ms_allowin);
    assign es_to_ms_valid = es_valid_q && ES_READY_GO && !flush;

    always_comb begin
        es_valid_d = es_valid_q;
        if (flush)           es_valid_d = 1'b0;
        else if (es_allowin) es_valid_d = ds_to_es_valid;

        ds_bus_d = ds_bus_q;
        if (ds_to_es_valid && es_allowin && !flush) ds_bus_d = ds_to_es_bus;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            ds_bus_q   <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            ds_bus_q   <= ds_bus_d;
        end
    end

    // Registered instruction fields.
    logic [31:0]         es_pc, es_src1, es_src2, es_rkd, es_alu_result;
    logic [ALU_OP_W-1:0] es_alu_op;
    logic [4:0]          es_dest;
    logic                es_gr_we, es_mem_we, es_res_from_mem, es_mem_unsigned;
    mem_size_e           es_mem_size;

    assign es_pc           = ds_bus_q[DS_PC_LSB +: 32];
    assign es_alu_op       = ds_bus_q[DS_ALU_OP_LSB +: ALU_OP_W];
    assign es_src1         = ds_bus_q[DS_SRC1_LSB +: 32];
    assign es_src2         = ds_bus_q[DS_SRC2_LSB +: 32];
    assign es_rkd          = ds_bus_q[DS_RKD_LSB +: 32];
    assign es_gr_we        = ds_bus_q[DS_GR_WE];
    assign es_dest         = ds_bus_q[DS_DEST_LSB +: 5];
    assign es_mem_we       = ds_bus_q[DS_MEM_WE];
    assign es_res_from_mem = ds_bus_q[DS_RES_FROM_MEM];
    assign es_mem_size     = mem_size_e'(ds_bus_q[DS_MEM_SIZE_LSB +: 2]);
    assign es_mem_unsigned = ds_bus_q[DS_MEM_UNSIGNED];

    alu u_alu (
        .alu_op     (es_alu_op),
        .alu_src1   (es_src1),
        .alu_src2   (es_src2),
        .alu_result (es_alu_result)
    );

    // The request is tied to the hand-off cycle so a stalled memory
    // instruction issues exactly one access.
    logic sram_en;
    assign sram_en = es_valid_q && (es_mem_we || es_res_from_mem)
                  && ms_allowin && !flush;

    // NOTE: every signal in this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sram.data_sram_we    = 4'b0000;
        sram.data_sram_wdata = es_rkd;
        case (es_mem_size)
            SIZE_B: begin
                sram.data_sram_wdata = {4{es_rkd[7:0]}};
                if (sram_en && es_mem_we)
                    sram.data_sram_we = 4'b0001 << es_alu_result[1:0];
            end
            SIZE_H: begin
                // addr[0] is deliberately ignored: no misalignment trap here.
                sram.data_sram_wdata = {2{es_rkd[15:0]}};
                if (sram_en && es_mem_we)
                    sram.data_sram_we = es_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                if (sram_en && es_mem_we) sram.data_sram_we = 4'b1111;
            end
        endcase
    end

    assign sram.data_sram_en   = sram_en;
    assign sram.data_sram_addr = es_alu_result;

    assign es_to_ms_bus = {es_pc, es_alu_result, es_gr_we, es_dest,
                           es_res_from_mem, es_mem_size, es_mem_unsigned,
                           es_alu_result[1:0]};

    assign es_fwd_bus = {es_valid_q && es_gr_we && (es_dest != 5'd0),
                         es_dest, es_alu_result,
                         es_valid_q && es_res_from_mem};

endmodule

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage
//   Directed vectors for exe_stage; expected MS-bus transfers and SRAM
//   requests are queued at issue time and popped by negedge monitors.
// ---------------------------------------------------------------------------
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset, flush, ms_allowin, ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_allowin, es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus;

    always #5 clk = ~clk;

    exe_stage_if sram_if ();

    exe_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .ms_allowin     (ms_allowin),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .es_fwd_bus     (es_fwd_bus),
        .sram           (sram_if)
    );

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    typedef struct {
        int          op;
        logic [31:0] s1, s2;
        logic [4:0]  dest;
        logic [31:0] res;
    } alu_vec_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] s1, s2, rkd;
        logic [3:0]  we;
        logic [31:0] addr, wdata;
    } st_vec_t;

    logic [ES_TO_MS_BUS_WD-1:0] ms_q[$];
    sram_req_t                  sram_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DS_TO_ES_BUS_WD-1:0] mk_ds(
        input logic [31:0] pc, input int op, input logic [31:0] s1,
        input logic [31:0] s2, input logic [31:0] rkd, input logic gr_we,
        input logic [4:0] dest, input logic mem_we, input logic rfm,
        input logic [1:0] size, input logic uns);
        logic [14:0] oh;
        oh     = '0;
        oh[op] = 1'b1;
        return {pc, oh, s1, s2, rkd, gr_we, dest, mem_we, rfm, size, uns};
    endfunction

    function automatic logic [ES_TO_MS_BUS_WD-1:0] mk_ms(
        input logic [31:0] pc, input logic [31:0] res, input logic gr_we,
        input logic [4:0] dest, input logic rfm, input logic [1:0] size,
        input logic uns);
        return {pc, res, gr_we, dest, rfm, size, uns, res[1:0]};
    endfunction

    task automatic send(input logic [DS_TO_ES_BUS_WD-1:0] bus);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = bus;
        @(posedge clk);
        #1;
        ds_to_es_valid = 1'b0;
    endtask

    // MS-side monitor: every hand-off must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && es_to_ms_valid && ms_allowin) begin
            if (ms_q.size() == 0) check("ms_unexpected", es_to_ms_valid, 1'b0);
            else                  check("ms_bus", es_to_ms_bus, ms_q.pop_front());
        end
    end

    // SRAM-side monitor: every request must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && sram_if.data_sram_en) begin
            if (sram_q.size() == 0) begin
                check("sram_unexpected", sram_if.data_sram_en, 1'b0);
            end else begin
                sram_req_t r;
                r = sram_q.pop_front();
                check("sram_we",    sram_if.data_sram_we,    r.we);
                check("sram_addr",  sram_if.data_sram_addr,  r.addr);
                check("sram_wdata", sram_if.data_sram_wdata, r.wdata);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        alu_vec_t    alu_tab[10];
        st_vec_t     st_tab[5];
        logic [31:0] pc;

        alu_tab = '{
            '{OP_ADD,     32'h7fffffff, 32'h00000001, 5'd5, 32'h80000000},
            '{OP_SUB,     32'h00000005, 32'h00000007, 5'd0, 32'hfffffffe},
            '{OP_SLT,     32'hffffffff, 32'h00000001, 5'd3, 32'h00000001},
            '{OP_SLTU,    32'hffffffff, 32'h00000001, 5'd3, 32'h00000000},
            '{OP_SRA,     32'h80000000, 32'h00000004, 5'd4, 32'hf8000000},
            '{OP_MULH_W,  32'hfffffffe, 32'h00000003, 5'd6, 32'hffffffff},
            '{OP_MULH_WU, 32'hfffffffe, 32'h00000003, 5'd6, 32'h00000002},
            '{OP_MUL_W,   32'hfffffffe, 32'h00000003, 5'd6, 32'hfffffffa},
            '{OP_NOR,     32'h0f0f0f0f, 32'h00ff00ff, 5'd8, 32'hf000f000},
            '{OP_LUI,     32'h00000000, 32'h12345000, 5'd9, 32'h12345000}
        };
        st_tab = '{
            '{SIZE_B, 32'h1000, 32'h3, 32'h000000a5, 4'b1000, 32'h1003, 32'ha5a5a5a5},
            '{SIZE_B, 32'h1000, 32'h0, 32'h0000005a, 4'b0001, 32'h1000, 32'h5a5a5a5a},
            '{SIZE_H, 32'h2000, 32'h2, 32'h1234beef, 4'b1100, 32'h2002, 32'hbeefbeef},
            '{SIZE_H, 32'h2000, 32'h1, 32'hcafe8001, 4'b0011, 32'h2001, 32'h80018001},
            '{SIZE_W, 32'h3000, 32'h1, 32'hdeadbeef, 4'b1111, 32'h3001, 32'hdeadbeef}
        };

        reset = 1'b1; flush = 1'b0; ms_allowin = 1'b1;
        ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_allowin",  es_allowin,            1'b1);
        check("rst_ms_valid", es_to_ms_valid,        1'b0);
        check("rst_ms_bus",   es_to_ms_bus,          76'd0);
        check("rst_fwd",      es_fwd_bus,            39'd0);
        check("rst_sram_en",  sram_if.data_sram_en,  1'b0);
        check("rst_sram_we",  sram_if.data_sram_we,  4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // ALU ops, back to back.
        pc = 32'h1c000000;
        foreach (alu_tab[i]) begin
            ms_q.push_back(mk_ms(pc, alu_tab[i].res, 1'b1, alu_tab[i].dest,
                                 1'b0, SIZE_W, 1'b0));
            send(mk_ds(pc, alu_tab[i].op, alu_tab[i].s1, alu_tab[i].s2, 32'h0,
                       1'b1, alu_tab[i].dest, 1'b0, 1'b0, SIZE_W, 1'b0));
            @(negedge clk);
            check("alu_ms_valid", es_to_ms_valid, 1'b1);
            check("alu_fwd", es_fwd_bus, {alu_tab[i].dest != 5'd0,
                  alu_tab[i].dest, alu_tab[i].res, 1'b0});
            check("alu_sram_en", sram_if.data_sram_en, 1'b0);
            pc = pc + 32'd4;
        end

        // Stores: lane enables and replicated write data.
        foreach (st_tab[i]) begin
            ms_q.push_back(mk_ms(pc, st_tab[i].addr, 1'b0, 5'd0, 1'b0,
                                 st_tab[i].size, 1'b0));
            sram_q.push_back('{st_tab[i].we, st_tab[i].addr, st_tab[i].wdata});
            send(mk_ds(pc, OP_ADD, st_tab[i].s1, st_tab[i].s2, st_tab[i].rkd,
                       1'b0, 5'd0, 1'b1, 1'b0, st_tab[i].size, 1'b0));
            @(negedge clk);
            check("st_fwd_we", es_fwd_bus[FWD_WE], 1'b0);
            pc = pc + 32'd4;
        end
        @(posedge clk); #1;

        // ld.w under back-pressure, with a younger ADD waiting in ID.
        ms_allowin = 1'b0;
        ms_q.push_back(mk_ms(pc, 32'h4008, 1'b1, 5'd7, 1'b1, SIZE_W, 1'b0));
        sram_q.push_back('{4'b0000, 32'h4008, 32'h11223344});
        send(mk_ds(pc, OP_ADD, 32'h4000, 32'h8, 32'h11223344, 1'b1, 5'd7,
                   1'b0, 1'b1, SIZE_W, 1'b0));
        pc = pc + 32'd4;
        ms_q.push_back(mk_ms(pc, 32'h3, 1'b1, 5'd9, 1'b0, SIZE_W, 1'b0));
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk_ds(pc, OP_ADD, 32'h1, 32'h2, 32'h0, 1'b1, 5'd9,
                               1'b0, 1'b0, SIZE_W, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_sram_en",  sram_if.data_sram_en, 1'b0);
            check("stall_allowin",  es_allowin,           1'b0);
            check("stall_ms_valid", es_to_ms_valid,       1'b1);
            check("stall_fwd",      es_fwd_bus, {1'b1, 5'd7, 32'h4008, 1'b1});
            @(posedge clk); #1;
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        check("ld_sram_en", sram_if.data_sram_en, 1'b1);
        check("ld_allowin", es_allowin,           1'b1);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        check("add2_sram_en", sram_if.data_sram_en, 1'b0);
        check("add2_fwd",     es_fwd_bus, {1'b1, 5'd9, 32'h3, 1'b0});

        // Flush while a store sits in EX and a load is offered by ID.
        pc = pc + 32'd4;
        send(mk_ds(pc, OP_ADD, 32'h5000, 32'h0, 32'h77, 1'b0, 5'd0,
                   1'b1, 1'b0, SIZE_W, 1'b0));
        flush = 1'b1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk_ds(pc + 32'd4, OP_ADD, 32'h6000, 32'h0, 32'h0,
                               1'b1, 5'd10, 1'b0, 1'b1, SIZE_W, 1'b0);
        @(negedge clk);
        check("flush_ms_valid", es_to_ms_valid,       1'b0);
        check("flush_sram_en",  sram_if.data_sram_en, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; ds_to_es_valid = 1'b0; ms_allowin = 1'b0;
        @(negedge clk);
        check("post_flush_empty",    es_allowin,          1'b1);
        check("post_flush_ms_valid", es_to_ms_valid,      1'b0);
        check("post_flush_fwd_we",   es_fwd_bus[FWD_WE],      1'b0);
        check("post_flush_is_load",  es_fwd_bus[FWD_IS_LOAD], 1'b0);

        // Asynchronous reset while a stalled store is held.
        @(posedge clk); #1;
        pc = pc + 32'd8;
        send(mk_ds(pc, OP_ADD, 32'h7000, 32'h4, 32'h55, 1'b0, 5'd0,
                   1'b1, 1'b0, SIZE_W, 1'b0));
        @(negedge clk);
        check("pre_rst_ms_valid", es_to_ms_valid, 1'b1);
        #1;
        reset = 1'b1;
        ms_allowin = 1'b1;
        #1;
        check("async_rst_ms_valid", es_to_ms_valid,       1'b0);
        check("async_rst_allowin",  es_allowin,           1'b1);
        check("async_rst_sram_en",  sram_if.data_sram_en, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("after_rst_ms_valid", es_to_ms_valid,       1'b0);
        check("after_rst_sram_en",  sram_if.data_sram_en, 1'b0);

        check("ms_q_drained",   ms_q.size(),   0);
        check("sram_q_drained", sram_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
